// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the top-5 sorter pipeline.
//   - default field widths, list depth and candidate count
//   - entry layout: {index, data}, data in the LSBs
//   - entry_beats(): the ranking rule used by every merge stage
package sort_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_DEF  = 16;
   localparam int TOP_K      = 5;
   localparam int NUM_IN     = 2 * TOP_K;          // high + low candidates per beat
   localparam int NUM_CAND   = NUM_IN + TOP_K;     // plus the running list
   localparam int RANK_W     = $clog2(NUM_CAND + 1);

   // Entry layout. Data occupies [DATA_LSB +: Data_Width]; the index sits
   // directly above it, starting at bit Data_Width.
   localparam int DATA_LSB   = 0;
   localparam int ENTRY_MAX  = 64;                 // widest entry entry_beats accepts

   // True when entry a ranks strictly above entry b: larger unsigned data
   // wins, equal data falls back to the smaller index. Entries are passed
   // zero-extended; dw gives the data field width.
   function automatic logic entry_beats(input logic [ENTRY_MAX-1:0] a,
                                        input logic [ENTRY_MAX-1:0] b,
                                        input int                   dw = DATA_W_DEF);
      logic [ENTRY_MAX-1:0] mask;
      logic [ENTRY_MAX-1:0] a_dat, b_dat, a_idx, b_idx;
      mask  = (ENTRY_MAX'(1) << dw) - ENTRY_MAX'(1);
      a_dat = (a >> DATA_LSB) & mask;
      b_dat = (b >> DATA_LSB) & mask;
      a_idx = a >> dw;
      b_idx = b >> dw;
      return (a_dat > b_dat) || ((a_dat == b_dat) && (a_idx < b_idx));
   endfunction

endpackage

// File: rtl/sort_rank_sel.sv
// sort_rank_sel: combinational rank-and-place network.
// Every valid candidate counts how many valid candidates beat it; that
// count is its output slot. Candidates ranked TOP_K or worse drop out.
// Ports:
//   cand_i      NUM_CAND entries, {index,data}
//   cand_vld_i  per-candidate valid; invalid candidates neither place nor beat
//   top_o       TOP_K best entries, slot 0 = largest, empty slots are 0
//   top_vld_o   per-slot valid
module sort_rank_sel
   import sort_pkg::*;
#(
   parameter  int Data_Width  = DATA_W_DEF,
   parameter  int Index_Width = IDX_W_DEF,
   localparam int EW          = Data_Width + Index_Width
)(
   input  logic [NUM_CAND-1:0][EW-1:0] cand_i,
   input  logic [NUM_CAND-1:0]         cand_vld_i,
   output logic [TOP_K-1:0][EW-1:0]    top_o,
   output logic [TOP_K-1:0]            top_vld_o
);

   // beats[i][j]: candidate j ranks above candidate i
   logic [NUM_CAND-1:0][NUM_CAND-1:0] beats;
   logic [NUM_CAND-1:0][RANK_W-1:0]   rank;

   for (genvar i = 0; i < NUM_CAND; i++) begin : g_row
      for (genvar j = 0; j < NUM_CAND; j++) begin : g_col
         if (i == j) begin : g_self
            assign beats[i][j] = 1'b0;
         end else begin : g_cmp
            // Bit-identical entries would otherwise share a rank and collide
            // in one slot; the lower candidate position wins such a tie.
            assign beats[i][j] = cand_vld_i[j] &
               (entry_beats(ENTRY_MAX'(cand_i[j]), ENTRY_MAX'(cand_i[i]), Data_Width) |
                ((j < i) && (cand_i[j] == cand_i[i])));
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CAND; i++) begin
         rank[i] = '0;
         for (int j = 0; j < NUM_CAND; j++)
            rank[i] = rank[i] + RANK_W'(beats[i][j]);
      end
   end

   // Ranks are unique, so each slot has at most one contributor and an OR
   // reduction is enough to place it.
   always_comb begin
      top_o     = '0;
      top_vld_o = '0;
      for (int s = 0; s < TOP_K; s++) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_vld_i[i] && (rank[i] == RANK_W'(s))) begin
               top_o[s]     = top_o[s] | cand_i[i];
               top_vld_o[s] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sort_e3_merge.sv
// sort_e3_merge: final sorter stage. Merges each E2 beat (5 high + 5 low
// candidates) into a running global top-5 and publishes it on the rising
// edge of E2_last_sort.
// Ports:
//   sys_clk / sys_rst_n          clock, async active-low reset
//   sorter_clr                   sync clear of all state (below reset only)
//   E2H_sorter_out0..4           high-half candidates {index,data}
//   E2L_sorter_out0..4           low-half candidates {index,data}
//   E2_sort_en                   one candidate beat this cycle
//   E2_last_sort                 end-of-frame level; its rising edge finalizes
//   E3_top_out0..4 / E3_top_vld  published top-5, slot 0 = largest
//   E3_result_valid              one-cycle pulse with each publish
//   E3_busy                      a frame has accumulated beats
//   E3_beat_cnt                  beats merged in the last finished frame
module sort_e3_merge
   import sort_pkg::*;
#(
   parameter  int Data_Width  = DATA_W_DEF,
   parameter  int Index_Width = IDX_W_DEF,
   localparam int EW          = Data_Width + Index_Width
)(
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   sorter_clr,
   input  logic [EW-1:0]          E2H_sorter_out0,
   input  logic [EW-1:0]          E2H_sorter_out1,
   input  logic [EW-1:0]          E2H_sorter_out2,
   input  logic [EW-1:0]          E2H_sorter_out3,
   input  logic [EW-1:0]          E2H_sorter_out4,
   input  logic [EW-1:0]          E2L_sorter_out0,
   input  logic [EW-1:0]          E2L_sorter_out1,
   input  logic [EW-1:0]          E2L_sorter_out2,
   input  logic [EW-1:0]          E2L_sorter_out3,
   input  logic [EW-1:0]          E2L_sorter_out4,
   input  logic                   E2_sort_en,
   input  logic                   E2_last_sort,
   output logic [EW-1:0]          E3_top_out0,
   output logic [EW-1:0]          E3_top_out1,
   output logic [EW-1:0]          E3_top_out2,
   output logic [EW-1:0]          E3_top_out3,
   output logic [EW-1:0]          E3_top_out4,
   output logic [TOP_K-1:0]       E3_top_vld,
   output logic                   E3_result_valid,
   output logic                   E3_busy,
   output logic [Index_Width-1:0] E3_beat_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

   localparam logic [Index_Width-1:0] CNT_ONE = Index_Width'(1);

   // running list and frame bookkeeping
   logic [TOP_K-1:0][EW-1:0] run_q, run_d;
   logic [TOP_K-1:0]         run_vld_q, run_vld_d;
   logic [Index_Width-1:0]   cnt_q, cnt_d;
   logic                     last_q, last_d;
   // published result
   logic [TOP_K-1:0][EW-1:0] top_q, top_d;
   logic [TOP_K-1:0]         top_vld_q, top_vld_d;
   logic                     res_vld_q, res_vld_d;
   logic [Index_Width-1:0]   bcnt_q, bcnt_d;
   // FSM
   state_e                   state_q;
   logic                     busy_q;

   logic [NUM_CAND-1:0][EW-1:0] cand;
   logic [NUM_CAND-1:0]         cand_vld;
   logic [TOP_K-1:0][EW-1:0]    mrg;
   logic [TOP_K-1:0]            mrg_vld;
   logic [TOP_K-1:0][EW-1:0]    src;
   logic [TOP_K-1:0]            src_vld;
   logic [Index_Width-1:0]      cnt_inc;
   logic                        fin;

   // Candidates 0..4 high half, 5..9 low half, 10..14 running list.
   assign cand = {run_q,
                  E2L_sorter_out4, E2L_sorter_out3, E2L_sorter_out2,
                  E2L_sorter_out1, E2L_sorter_out0,
                  E2H_sorter_out4, E2H_sorter_out3, E2H_sorter_out2,
                  E2H_sorter_out1, E2H_sorter_out0};
   assign cand_vld = {run_vld_q, {NUM_IN{1'b1}}};

   sort_rank_sel #(
      .Data_Width  (Data_Width),
      .Index_Width (Index_Width)
   ) u_rank_sel (
      .cand_i     (cand),
      .cand_vld_i (cand_vld),
      .top_o      (mrg),
      .top_vld_o  (mrg_vld)
   );

   assign fin = E2_last_sort & ~last_q;

   always_comb begin
      cnt_inc   = (E2_sort_en && (cnt_q != '1)) ? cnt_q + CNT_ONE : cnt_q;
      // A coincident beat is merged before anything is published.
      src       = E2_sort_en ? mrg     : run_q;
      src_vld   = E2_sort_en ? mrg_vld : run_vld_q;

      run_d     = src;
      run_vld_d = src_vld;
      cnt_d     = cnt_inc;
      last_d    = E2_last_sort;
      top_d     = top_q;
      top_vld_d = top_vld_q;
      res_vld_d = 1'b0;
      bcnt_d    = bcnt_q;

      if (fin) begin
         top_d     = src;
         top_vld_d = src_vld;
         res_vld_d = 1'b1;
         bcnt_d    = cnt_inc;
         run_d     = '0;
         run_vld_d = '0;
         cnt_d     = '0;
      end

      if (sorter_clr) begin
         run_d     = '0;
         run_vld_d = '0;
         cnt_d     = '0;
         last_d    = 1'b0;
         top_d     = '0;
         top_vld_d = '0;
         res_vld_d = 1'b0;
         bcnt_d    = '0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_q     <= '0;
         run_vld_q <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         top_q     <= '0;
         top_vld_q <= '0;
         res_vld_q <= 1'b0;
         bcnt_q    <= '0;
      end else begin
         run_q     <= run_d;
         run_vld_q <= run_vld_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         top_q     <= top_d;
         top_vld_q <= top_vld_d;
         res_vld_q <= res_vld_d;
         bcnt_q    <= bcnt_d;
      end
   end

   // A beat arriving with finalize closes its own frame, so it never
   // leaves IDLE.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else if (sorter_clr) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (E2_sort_en && !fin) begin
                  state_q <= ST_ACCUM;
                  busy_q  <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (fin) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign E3_top_out0     = top_q[0];
   assign E3_top_out1     = top_q[1];
   assign E3_top_out2     = top_q[2];
   assign E3_top_out3     = top_q[3];
   assign E3_top_out4     = top_q[4];
   assign E3_top_vld      = top_vld_q;
   assign E3_result_valid = res_vld_q;
   assign E3_busy         = busy_q;
   assign E3_beat_cnt     = bcnt_q;

endmodule
